// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Glyphs are active-low in abcdefg order: bit 6 = segment a, bit 0 = segment g.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_encoder.sv
// Combinational nibble-to-glyph encoder, active-low abcdefg output.
// Ports:
//   nibble  - 4-bit digit value
//   blank   - force all segments off
//   glyph_c - active-low segment pattern (never X; unsupported codes are blank)
module seg7_encoder
    import display_pkg::*;
#(
    parameter int unsigned HEX_MODE = 0
) (
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] glyph_c
);

    localparam logic HEX_EN = 1'(HEX_MODE != 0);

    // Codes 10..15 show letters only in hex mode, blank otherwise.
    always_comb begin
        glyph_c = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'h0: glyph_c = SEG_0;
                4'h1: glyph_c = SEG_1;
                4'h2: glyph_c = SEG_2;
                4'h3: glyph_c = SEG_3;
                4'h4: glyph_c = SEG_4;
                4'h5: glyph_c = SEG_5;
                4'h6: glyph_c = SEG_6;
                4'h7: glyph_c = SEG_7;
                4'h8: glyph_c = SEG_8;
                4'h9: glyph_c = SEG_9;
                4'hA: glyph_c = HEX_EN ? SEG_A : SEG_BLANK;
                4'hB: glyph_c = HEX_EN ? SEG_B : SEG_BLANK;
                4'hC: glyph_c = HEX_EN ? SEG_C : SEG_BLANK;
                4'hD: glyph_c = HEX_EN ? SEG_D : SEG_BLANK;
                4'hE: glyph_c = HEX_EN ? SEG_E : SEG_BLANK;
                4'hF: glyph_c = HEX_EN ? SEG_F : SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/display_mux_7seg.sv
// N-digit time-multiplexed 7-segment display driver with a dead cycle between
// digit slots, leading-zero blanking and per-digit decimal points.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   load       - capture value/dp_in/lz_en into the shadow registers
//   value      - packed nibbles, digit i = value[4i+3:4i]
//   dp_in      - decimal point per digit (1 = lit)
//   lz_en      - leading-zero blanking enable
//   seg        - segments a..g on seg[6]..seg[0] (registered)
//   dp         - decimal point of the active digit (registered)
//   an         - one-hot digit enable (registered)
//   digit_idx  - index of the digit owning the current slot
module display_mux_7seg
    import display_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned HEX_MODE    = 0,
    parameter int unsigned ACTIVE_LOW  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [4*N_DIGITS-1:0]         value,
    input  logic [N_DIGITS-1:0]           dp_in,
    input  logic                          lz_en,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [N_DIGITS-1:0]           an,
    output logic [$clog2(N_DIGITS)-1:0]   digit_idx
);

    localparam int unsigned IDX_W = $clog2(N_DIGITS);
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    // INV flips every output polarity for active-high boards.
    localparam logic                INV     = 1'(ACTIVE_LOW == 0);
    localparam logic [6:0]          SEG_OFF = SEG_BLANK ^ {7{INV}};
    localparam logic                DP_OFF  = ~INV;
    localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{~INV}};

    logic [4*N_DIGITS-1:0] value_q, value_d;
    logic [N_DIGITS-1:0]   dp_in_q, dp_in_d;
    logic                  lz_en_q, lz_en_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;

    logic                  tick_c;
    logic [3:0]            nibble_c;
    logic                  blank_c;
    logic [6:0]            glyph_c;
    logic [N_DIGITS-1:0]   lz_blank_c;

    assign tick_c = (cnt_q == CNT_W'(REFRESH_DIV - 1));

    // Digit i is blanked when it and every more significant nibble are zero; digit 0 always shows.
    always_comb begin : lz_mask
        logic zero_above;
        zero_above = 1'b1;
        lz_blank_c = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_above    = zero_above & (value_q[4*i +: 4] == 4'h0);
            lz_blank_c[i] = lz_en_q & zero_above & (i != 0);
        end
    end

    assign nibble_c = value_q[{idx_q, 2'b00} +: 4];
    assign blank_c  = lz_blank_c[idx_q];

    seg7_encoder #(
        .HEX_MODE (HEX_MODE)
    ) u_encoder (
        .nibble  (nibble_c),
        .blank   (blank_c),
        .glyph_c (glyph_c)
    );

    // Shadow capture, prescaler/scan advance and output selection.
    // A tick edge turns the outputs off for one cycle while the index moves on.
    always_comb begin
        value_d = value_q;
        dp_in_d = dp_in_q;
        lz_en_d = lz_en_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        seg_d   = SEG_OFF;
        dp_d    = DP_OFF;
        an_d    = AN_OFF;

        if (load) begin
            value_d = value;
            dp_in_d = dp_in;
            lz_en_d = lz_en;
        end

        if (tick_c) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            seg_d = glyph_c ^ {7{INV}};
            dp_d  = ~dp_in_q[idx_q] ^ INV;
            an_d  = ~(N_DIGITS'(1) << idx_q) ^ {N_DIGITS{INV}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            dp_in_q <= '0;
            lz_en_q <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_OFF;
            dp_q    <= DP_OFF;
            an_q    <= AN_OFF;
        end else begin
            value_q <= value_d;
            dp_in_q <= dp_in_d;
            lz_en_q <= lz_en_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_display_mux_7seg.sv
// Bench for display_mux_7seg: decimal, hex and active-high instances share one
// stimulus; expected outputs are queued per cycle and checked on the falling edge.
module tb_display_mux_7seg;

    localparam int unsigned N = 4;
    localparam int unsigned R = 4;

    typedef struct packed {
        int unsigned n;
        logic [6:0]  seg;
        logic [6:0]  seg_h;
        logic        dp;
        logic [3:0]  an;
        logic [1:0]  idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        lz_en;

    logic [6:0] seg_a, seg_h, seg_i;
    logic       dp_a, dp_h, dp_i;
    logic [3:0] an_a, an_h, an_i;
    logic [1:0] idx_a, idx_h, idx_i;

    int unsigned n_edges = 0;
    int          n_cmp   = 0;
    int          n_bad   = 0;
    exp_t        sb[$];

    logic [15:0] sh_v;
    logic [3:0]  sh_dp;
    logic        sh_lz;

    display_mux_7seg #(.N_DIGITS(N), .REFRESH_DIV(R), .HEX_MODE(0), .ACTIVE_LOW(1)) u_dec (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .lz_en(lz_en),
        .seg(seg_a), .dp(dp_a), .an(an_a), .digit_idx(idx_a));

    display_mux_7seg #(.N_DIGITS(N), .REFRESH_DIV(R), .HEX_MODE(1), .ACTIVE_LOW(1)) u_hex (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .lz_en(lz_en),
        .seg(seg_h), .dp(dp_h), .an(an_h), .digit_idx(idx_h));

    display_mux_7seg #(.N_DIGITS(N), .REFRESH_DIV(R), .HEX_MODE(0), .ACTIVE_LOW(0)) u_inv (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .lz_en(lz_en),
        .seg(seg_i), .dp(dp_i), .an(an_i), .digit_idx(idx_i));

    always #5 clk = ~clk;

    // Edges since reset release: the cycle after edge n is the bench's time base.
    always @(posedge clk or posedge rst) begin
        if (rst) n_edges <= 0;
        else     n_edges <= n_edges + 1;
    end

    function automatic logic [6:0] glyph(input logic [3:0] nib, input bit hex);
        logic [6:0] t [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        if (!hex && nib > 4'd9) return 7'h7F;
        return t[nib];
    endfunction

    // Outputs during the cycle after edge n: slot k covers edges k*R..k*R+R-1,
    // the first edge of each slot (except after reset) is the dead cycle.
    function automatic exp_t model(input int unsigned n, input logic [15:0] v,
                                   input logic [3:0] dv, input logic lz);
        exp_t e;
        int   d;
        logic blank;
        d       = int'((n / R) % N);
        e.n     = n;
        e.idx   = 2'(d);
        e.seg   = 7'h7F;
        e.seg_h = 7'h7F;
        e.dp    = 1'b1;
        e.an    = 4'hF;
        if (n != 0 && (n % R) != 0) begin
            blank   = lz && (d != 0) && ((v >> (4 * d)) == 16'h0);
            e.seg   = blank ? 7'h7F : glyph(4'(v >> (4 * d)), 1'b0);
            e.seg_h = blank ? 7'h7F : glyph(4'(v >> (4 * d)), 1'b1);
            e.dp    = ~dv[d];
            e.an    = ~(4'b0001 << d);
        end
        return e;
    endfunction

    // Load pulse across one edge L; queues cycle L (old shadow) and L+1..L+k (new).
    task automatic do_load(input logic [15:0] v, input logic [3:0] dv, input logic lz,
                           input int unsigned k);
        logic [15:0] ov  = sh_v;
        logic [3:0]  odp = sh_dp;
        logic        olz = sh_lz;
        load  = 1'b1;
        value = v;
        dp_in = dv;
        lz_en = lz;
        @(posedge clk);
        #1;
        load  = 1'b0;
        value = 16'($urandom);
        dp_in = 4'($urandom);
        lz_en = 1'($urandom);
        sh_v  = v;
        sh_dp = dv;
        sh_lz = lz;
        sb.push_back(model(n_edges, ov, odp, olz));
        for (int i = 1; i <= int'(k); i++) sb.push_back(model(n_edges + i, v, dv, lz));
    endtask

    task automatic test_reset();
        exp_t e;
        rst   = 1'b1;
        load  = 1'b0;
        value = 16'h0;
        dp_in = 4'h0;
        lz_en = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({seg_a, dp_a, an_a, idx_a} !== {7'h7F, 1'b1, 4'hF, 2'd0}) begin
            n_bad++;
            $display("FAIL reset/dec got seg=%b dp=%b an=%b idx=%0d want 1111111 1 1111 0", seg_a, dp_a, an_a, idx_a);
        end
        n_cmp++;
        if ({seg_h, dp_h, an_h, idx_h} !== {7'h7F, 1'b1, 4'hF, 2'd0}) begin
            n_bad++;
            $display("FAIL reset/hex got seg=%b dp=%b an=%b idx=%0d want 1111111 1 1111 0", seg_h, dp_h, an_h, idx_h);
        end
        n_cmp++;
        if ({seg_i, dp_i, an_i, idx_i} !== {7'h00, 1'b0, 4'h0, 2'd0}) begin
            n_bad++;
            $display("FAIL reset/inv got seg=%b dp=%b an=%b idx=%0d want 0000000 0 0000 0", seg_i, dp_i, an_i, idx_i);
        end
        rst   = 1'b0;
        sh_v  = '0;
        sh_dp = '0;
        sh_lz = 1'b0;
        for (int i = 1; i <= 8; i++) sb.push_back(model(i, sh_v, sh_dp, sh_lz));
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({seg_a, dp_a, an_a, idx_a} !== {e.seg, e.dp, e.an, e.idx}) begin
                n_bad++;
                $display("FAIL reset_scan/dec n=%0d got %b %b %b %0d want %b %b %b %0d", e.n, seg_a, dp_a, an_a, idx_a, e.seg, e.dp, e.an, e.idx);
            end
        end
    endtask

    task automatic test_patterns(input string tag, input logic [15:0] v, input logic [3:0] dv,
                                 input logic lz);
        exp_t e;
        do_load(v, dv, lz, 20);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({seg_a, dp_a, an_a, idx_a} !== {e.seg, e.dp, e.an, e.idx}) begin
                n_bad++;
                $display("FAIL %s/dec n=%0d got %b %b %b %0d want %b %b %b %0d", tag, e.n, seg_a, dp_a, an_a, idx_a, e.seg, e.dp, e.an, e.idx);
            end
            n_cmp++;
            if ({seg_h, dp_h, an_h, idx_h} !== {e.seg_h, e.dp, e.an, e.idx}) begin
                n_bad++;
                $display("FAIL %s/hex n=%0d got %b %b %b %0d want %b %b %b %0d", tag, e.n, seg_h, dp_h, an_h, idx_h, e.seg_h, e.dp, e.an, e.idx);
            end
            n_cmp++;
            if ({seg_i, dp_i, an_i, idx_i} !== {~e.seg, ~e.dp, ~e.an, e.idx}) begin
                n_bad++;
                $display("FAIL %s/inv n=%0d got %b %b %b %0d want %b %b %b %0d", tag, e.n, seg_i, dp_i, an_i, idx_i, ~e.seg, ~e.dp, ~e.an, e.idx);
            end
        end
    endtask

    task automatic test_scan();
        test_patterns("scan_1234", 16'h1234, 4'b0000, 1'b0);
    endtask

    task automatic test_lz();
        test_patterns("lz_0007", 16'h0007, 4'b0000, 1'b1);
        test_patterns("lz_0000", 16'h0000, 4'b0000, 1'b1);
        test_patterns("lz_0300", 16'h0300, 4'b0000, 1'b1);
    endtask

    task automatic test_glyphs();
        test_patterns("glyph_fa09", 16'hFA09, 4'b0000, 1'b0);
        test_patterns("glyph_bcde", 16'hBCDE, 4'b0000, 1'b0);
        test_patterns("glyph_5678", 16'h5678, 4'b0000, 1'b0);
    endtask

    task automatic test_dp();
        test_patterns("dp_0100", 16'h1234, 4'b0100, 1'b0);
        test_patterns("dp_blank", 16'h0005, 4'b1000, 1'b1);
    endtask

    // Load in the middle of digit 0's slot, then a load landing on a tick edge.
    task automatic test_back_to_back();
        exp_t e;
        for (int step = 0; step < 3; step++) begin
            if (step == 0) begin
                do_load(16'h1234, 4'b0000, 1'b0, 4);
            end else if (step == 1) begin
                while (n_edges % 16 != 1) @(negedge clk);
                do_load(16'h1238, 4'b0000, 1'b0, 14);
            end else begin
                while (n_edges % R != 3) @(negedge clk);
                do_load(16'h5678, 4'b0001, 1'b0, 12);
            end
            while (sb.size() != 0) begin
                @(negedge clk);
                e = sb.pop_front();
                n_cmp++;
                if ({seg_a, dp_a, an_a, idx_a} !== {e.seg, e.dp, e.an, e.idx}) begin
                    n_bad++;
                    $display("FAIL midload%0d/dec n=%0d got %b %b %b %0d want %b %b %b %0d", step, e.n, seg_a, dp_a, an_a, idx_a, e.seg, e.dp, e.an, e.idx);
                end
                n_cmp++;
                if ({seg_i, dp_i, an_i, idx_i} !== {~e.seg, ~e.dp, ~e.an, e.idx}) begin
                    n_bad++;
                    $display("FAIL midload%0d/inv n=%0d got %b %b %b %0d want %b %b %b %0d", step, e.n, seg_i, dp_i, an_i, idx_i, ~e.seg, ~e.dp, ~e.an, e.idx);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        while (n_edges % 16 != 6) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({seg_a, dp_a, an_a, idx_a} !== {7'h7F, 1'b1, 4'hF, 2'd0}) begin
            n_bad++;
            $display("FAIL async_rst/dec got seg=%b dp=%b an=%b idx=%0d want 1111111 1 1111 0", seg_a, dp_a, an_a, idx_a);
        end
        n_cmp++;
        if ({seg_i, dp_i, an_i, idx_i} !== {7'h00, 1'b0, 4'h0, 2'd0}) begin
            n_bad++;
            $display("FAIL async_rst/inv got seg=%b dp=%b an=%b idx=%0d want 0000000 0 0000 0", seg_i, dp_i, an_i, idx_i);
        end
        @(negedge clk);
        rst   = 1'b0;
        sh_v  = '0;
        sh_dp = '0;
        sh_lz = 1'b0;
        for (int i = 1; i <= 12; i++) sb.push_back(model(i, sh_v, sh_dp, sh_lz));
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({seg_a, dp_a, an_a, idx_a} !== {e.seg, e.dp, e.an, e.idx}) begin
                n_bad++;
                $display("FAIL async_rst_scan/dec n=%0d got %b %b %b %0d want %b %b %b %0d", e.n, seg_a, dp_a, an_a, idx_a, e.seg, e.dp, e.an, e.idx);
            end
            n_cmp++;
            if ({seg_h, dp_h, an_h, idx_h} !== {e.seg_h, e.dp, e.an, e.idx}) begin
                n_bad++;
                $display("FAIL async_rst_scan/hex n=%0d got %b %b %b %0d want %b %b %b %0d", e.n, seg_h, dp_h, an_h, idx_h, e.seg_h, e.dp, e.an, e.idx);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_scan();
        test_lz();
        test_glyphs();
        test_dp();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
